// File: rtl/jpeg_blk_sched.sv
// jpeg_blk_sched
//   Feeds 8x8 blocks from the Y/Cb/Cr component buffers into the shared
//   DCT -> zigzag -> quant -> entropy pipeline in MCU order. The supported
//   orders are 4:2:0 (Y,Y,Y,Y,Cb,Cr) and 4:4:4 (Y,Cb,Cr). Each block is a
//   64-cycle raster read burst tagged with its component id. A credit
//   counter bounds the number of blocks in flight, so the entropy coder
//   (the only stage that can stall) is never overrun.
//
// Parameters
//   CREDITS  max blocks between burst start and entropy completion (1..7)
//   MCU_W    width of the MCU count
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   start          frame start pulse (ignored unless idle)
//   abort          synchronous abort, overrides every other event
//   fmt_420        1: 4:2:0, 0: 4:4:4 (latched at start)
//   mcu_total      MCUs in the frame (latched at start)
//   blk_rdy[2:0]   per-component "full block available"
//   blk_ack[2:0]   one-cycle pulse in the final cycle of a burst
//   blk_done_in    credit return from the entropy coder
//   rd_en/rd_addr/rd_comp   component buffer read port
//   blk_start      first cycle of a burst (rd_addr == 0)
//   mcu_last_blk   burst belongs to the last block of an MCU
//   busy, done     activity flag and end-of-frame pulse
//   credit_err     sticky credit-return overflow flag
//   stall_cnt      arbitration stall cycles
//
// Build option
//   JPEG_BLK_SCHED_STALL_CNT_EN: when defined, stall_cnt counts ARB cycles
//   without a grant (saturating, cleared at start). When undefined, it is 0.

module jpeg_blk_sched #(
    parameter int CREDITS = 2,
    parameter int MCU_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             fmt_420,
    input  logic [MCU_W-1:0] mcu_total,
    input  logic [2:0]       blk_rdy,
    output logic [2:0]       blk_ack,
    input  logic             blk_done_in,
    output logic             rd_en,
    output logic [5:0]       rd_addr,
    output logic [1:0]       rd_comp,
    output logic             blk_start,
    output logic             mcu_last_blk,
    output logic             busy,
    output logic             done,
    output logic             credit_err,
    output logic [15:0]      stall_cnt
);
    typedef enum logic [1:0] {IDLE, ARB, BURST, DONE} state_t;

    localparam logic [2:0] CRED_MAX = 3'(CREDITS);

    state_t           state, state_nxt;
    logic             fmt_q;
    logic [MCU_W-1:0] total_q, mcu_cnt, mcu_cnt_inc;
    logic [2:0]       blk_idx, credit;
    logic [5:0]       addr;
    logic [1:0]       comp;
    logic             rdy_sel, last_idx, grant, frame_end, cred_dec, cred_inc;

    // Block slot -> component for the latched sampling format
    always_comb begin
        comp = 2'd0;
        if (fmt_q) begin
            if (blk_idx == 3'd4)      comp = 2'd1;
            else if (blk_idx == 3'd5) comp = 2'd2;
        end else begin
            comp = blk_idx[1:0];
        end
    end

    always_comb begin
        rdy_sel = 1'b0;
        case (comp)
            2'd0:    rdy_sel = blk_rdy[0];
            2'd1:    rdy_sel = blk_rdy[1];
            2'd2:    rdy_sel = blk_rdy[2];
            default: rdy_sel = 1'b0;
        endcase
    end

    assign last_idx    = fmt_q ? (blk_idx == 3'd5) : (blk_idx == 3'd2);
    assign mcu_cnt_inc = mcu_cnt + MCU_W'(1);
    // The slot is held until its own buffer is ready; later components are never promoted.
    assign grant       = (state == ARB) && rdy_sel && (credit != 3'd0);
    assign frame_end   = last_idx && (mcu_cnt_inc == total_q);
    assign cred_dec    = (state == BURST) && (addr == 6'd0);
    assign cred_inc    = blk_done_in;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        rd_en        = 1'b0;
        rd_addr      = 6'd0;
        rd_comp      = 2'd0;
        blk_start    = 1'b0;
        blk_ack      = 3'b000;
        mcu_last_blk = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (mcu_total == '0) ? DONE : ARB;
            end
            ARB: begin
                busy = 1'b1;
                if (grant) state_nxt = BURST;
            end
            BURST: begin
                busy         = 1'b1;
                rd_en        = 1'b1;
                rd_addr      = addr;
                rd_comp      = comp;
                blk_start    = (addr == 6'd0);
                mcu_last_blk = last_idx;
                if (addr == 6'd63) begin
                    // An aborted block is not consumed, so it is not acknowledged
                    if (!abort) blk_ack = 3'b001 << comp;
                    state_nxt = frame_end ? DONE : ARB;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // done is registered: it pulses in the cycle after DONE, as the FSM re-enters IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fmt_q      <= 1'b0;
            total_q    <= '0;
            mcu_cnt    <= '0;
            blk_idx    <= 3'd0;
            addr       <= 6'd0;
            credit     <= CRED_MAX;
            credit_err <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            mcu_cnt <= '0;
            blk_idx <= 3'd0;
            addr    <= 6'd0;
            credit  <= CRED_MAX;
            done    <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == IDLE && start) begin
                fmt_q      <= fmt_420;
                total_q    <= mcu_total;
                mcu_cnt    <= '0;
                blk_idx    <= 3'd0;
                credit_err <= 1'b0;
            end
            if (state == BURST) begin
                addr <= addr + 6'd1;
                if (addr == 6'd63) begin
                    if (last_idx) begin
                        blk_idx <= 3'd0;
                        mcu_cnt <= mcu_cnt_inc;
                    end else begin
                        blk_idx <= blk_idx + 3'd1;
                    end
                end
            end
            // A take and a return in the same cycle cancel out
            if (cred_inc && !cred_dec) begin
                if (credit == CRED_MAX) credit_err <= 1'b1;
                else                    credit     <= credit + 3'd1;
            end else if (cred_dec && !cred_inc) begin
                credit <= credit - 3'd1;
            end
        end
    end

`ifdef JPEG_BLK_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= 16'h0;
        end else if (!abort) begin
            if (state == IDLE && start)
                stall_q <= 16'h0;
            else if (state == ARB && !grant && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'h1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_jpeg_blk_sched.sv
// Testbench for jpeg_blk_sched: a directed stimulus thread queues the
// expected burst sequence, and a monitor checks each completed burst.
module tb_jpeg_blk_sched;
    localparam int CREDITS = 2;
    localparam int MCU_W   = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             fmt_420 = 1'b0;
    logic             blk_done_in = 1'b0;
    logic [MCU_W-1:0] mcu_total = '0;
    logic [2:0]       blk_rdy = 3'b000;
    logic [2:0]       blk_ack;
    logic             rd_en, blk_start, mcu_last_blk, busy, done, credit_err;
    logic [5:0]       rd_addr;
    logic [1:0]       rd_comp;
    logic [15:0]      stall_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] comp;
        int         len;
        bit         ack;
    } exp_t;

    exp_t sb_q[$];

    jpeg_blk_sched #(.CREDITS(CREDITS), .MCU_W(MCU_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .fmt_420      (fmt_420),
        .mcu_total    (mcu_total),
        .blk_rdy      (blk_rdy),
        .blk_ack      (blk_ack),
        .blk_done_in  (blk_done_in),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_comp      (rd_comp),
        .blk_start    (blk_start),
        .mcu_last_blk (mcu_last_blk),
        .busy         (busy),
        .done         (done),
        .credit_err   (credit_err),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input int len, input bit ack);
        exp_t e;
        e.comp = c;
        e.len  = len;
        e.ack  = ack;
        sb_q.push_back(e);
    endtask

    task automatic ret_pulse();
        blk_done_in = 1'b1;
        cyc();
        blk_done_in = 1'b0;
    endtask

    // Leaves the caller in the first cycle after start; the format inputs are
    // then disturbed to show that the latched values are used.
    task automatic start_frame(input logic f, input logic [MCU_W-1:0] n);
        fmt_420   = f;
        mcu_total = n;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
        fmt_420   = ~f;
        mcu_total = n + MCU_W'(5);
    endtask

    task automatic count_rd(input int n, output int n_rd);
        n_rd = 0;
        repeat (n) begin
            if (rd_en) n_rd++;
            cyc();
        end
    endtask

    // Runs until a done pulse (plus a short tail), optionally returning a
    // credit 3 cycles after every blk_ack.
    task automatic run(input int budget, input bit auto_ret, output int n_rd,
                       output int n_done, output int n_last, output bit timed_out);
        int pend = -1;
        int tail = -1;
        n_rd = 0; n_done = 0; n_last = 0; timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (rd_en) n_rd++;
            if (done) n_done++;
            if (mcu_last_blk) n_last++;
            blk_done_in = 1'b0;
            if (auto_ret) begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) blk_done_in = 1'b1;
                end
                if (blk_ack != 3'b000) pend = 3;
            end
            if (done && tail < 0) tail = 6;
            if (tail == 0) begin
                timed_out = 1'b0;
                break;
            end
            if (tail > 0) tail--;
            cyc();
        end
        blk_done_in = 1'b0;
    endtask

    // Burst monitor
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [1:0] mon_comp = 2'd0;
    logic [2:0] mon_ack = 3'b000;
    bit         mon_ok = 1'b1;
    exp_t       mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mon_active = 1'b0;
            end else if (rd_en) begin
                if (blk_start || !mon_active) begin
                    mon_ok     = blk_start;
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_comp   = rd_comp;
                    mon_ack    = 3'b000;
                end
                if (rd_addr != mon_cnt[5:0] || rd_comp != mon_comp) mon_ok = 1'b0;
                if (blk_ack != 3'b000) begin
                    mon_ack = mon_ack | blk_ack;
                    if (mon_cnt != 63) mon_ok = 1'b0;
                end
                mon_cnt++;
            end else begin
                if (blk_ack != 3'b000) chk("stray_ack", 32'(blk_ack), 32'd0);
                if (mon_active) begin
                    mon_active = 1'b0;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_burst", 32'(mon_comp), 32'd3);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("burst_comp", 32'(mon_comp), 32'(mon_e.comp));
                        chk("burst_len", mon_cnt, mon_e.len);
                        chk("burst_ack", 32'(mon_ack),
                            mon_e.ack ? 32'(3'b001 << mon_e.comp) : 32'd0);
                        chk("burst_addr_seq", 32'(mon_ok), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rd, n_done, n_last;
        bit to, found;

        // Reset state
        repeat (3) cyc();
        chk("reset_ctrl", 32'({rd_en, blk_start, mcu_last_blk, busy, done, credit_err, blk_ack}), 32'd0);
        chk("reset_addr", 32'({rd_addr, rd_comp}), 32'd0);
        chk("reset_stall", 32'(stall_cnt), 32'd0);
        rstn = 1'b1;
        cyc();

        // Credit return with all credits home
        ret_pulse();
        chk("credit_err_set", 32'(credit_err), 32'd1);
        repeat (3) cyc();
        chk("credit_err_sticky", 32'(credit_err), 32'd1);

        // 4:2:0, one MCU, credits withheld: two Y bursts then a stall
        blk_rdy = 3'b111;
        repeat (4) push(2'd0, 64, 1'b1);
        push(2'd1, 64, 1'b1);
        push(2'd2, 64, 1'b1);
        start_frame(1'b1, MCU_W'(1));
        chk("start_clears_err", 32'(credit_err), 32'd0);
        chk("lat_c1_rd_en", 32'(rd_en), 32'd0);
        cyc();
        chk("lat_c2_rd_en", 32'(rd_en), 32'd1);
        chk("lat_c2_blk_start", 32'(blk_start), 32'd1);
        count_rd(200, n_rd);
        chk("stall_rd_cycles", n_rd, 128);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_rd_en", 32'(rd_en), 32'd0);
`ifdef JPEG_BLK_SCHED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd71);
`else
        chk("stall_cnt_tied", 32'(stall_cnt), 32'd0);
`endif
        ret_pulse();
        chk("ret_c1_rd_en", 32'(rd_en), 32'd0);
        cyc();
        chk("ret_c2_rd_en", 32'(rd_en), 32'd1);
        chk("ret_c2_comp", 32'(rd_comp), 32'd0);
        run(3000, 1'b1, n_rd, n_done, n_last, to);
        chk("f420_rest_rd", n_rd, 256);
        chk("f420_done", n_done, 1);
        chk("f420_last_blk", n_last, 64);
        chk("f420_timeout", 32'(to), 32'd0);
        ret_pulse();

        // 4:4:4, two MCUs, credits returned 3 cycles after each ack
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 3; c++) push(2'(c), 64, 1'b1);
        start_frame(1'b0, MCU_W'(2));
        run(3000, 1'b1, n_rd, n_done, n_last, to);
        chk("f444_rd", n_rd, 384);
        chk("f444_done", n_done, 1);
        chk("f444_last_blk", n_last, 128);
        chk("f444_timeout", 32'(to), 32'd0);
        chk("f444_idle", 32'(busy), 32'd0);

        // Cb not ready: slot is held rather than skipped to Cr
        blk_rdy = 3'b101;
        for (int c = 0; c < 3; c++) push(2'(c), 64, 1'b1);
        start_frame(1'b0, MCU_W'(1));
        count_rd(100, n_rd);
        chk("hold_rd_cycles", n_rd, 64);
        chk("hold_rd_en", 32'(rd_en), 32'd0);
        blk_rdy = 3'b111;
        cyc();
        chk("hold_grant_rd_en", 32'(rd_en), 32'd1);
        chk("hold_grant_comp", 32'(rd_comp), 32'd1);
        blk_rdy = 3'b101;
        repeat (10) cyc();
        blk_rdy = 3'b111;
        run(3000, 1'b1, n_rd, n_done, n_last, to);
        chk("hold_rest_rd", n_rd, 118);
        chk("hold_done", n_done, 1);
        chk("hold_last_blk", n_last, 64);
        ret_pulse();

        // Return coinciding with blk_start leaves credit unchanged
        repeat (3) push(2'd0, 64, 1'b1);
        push(2'd0, 31, 1'b0);
        start_frame(1'b1, MCU_W'(1));
        cyc();
        chk("simul_blk_start", 32'(blk_start), 32'd1);
        blk_done_in = 1'b1;
        cyc();
        blk_done_in = 1'b0;
        count_rd(300, n_rd);
        chk("simul_rd_cycles", n_rd, 191);
        chk("simul_no_err", 32'(credit_err), 32'd0);
        chk("simul_stalled", 32'(rd_en), 32'd0);

        // Abort in the middle of a burst
        ret_pulse();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rd_en && rd_addr == 6'd30) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk("abort_addr30_reached", 32'(found), 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        count_rd(5, n_rd);
        chk("abort_quiet", 32'({done, rd_en}), 32'd0);

        // Restart after abort: slot 0 and full credits
        push(2'd0, 64, 1'b1);
        push(2'd1, 64, 1'b1);
        start_frame(1'b0, MCU_W'(1));
        count_rd(200, n_rd);
        chk("restart_rd_cycles", n_rd, 128);
        chk("restart_stalled", 32'({busy, rd_en}), 32'd2);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("restart_abort_idle", 32'(busy), 32'd0);

        // Empty frame
        start_frame(1'b0, MCU_W'(0));
        chk("empty_c1_done", 32'(done), 32'd0);
        chk("empty_c1_busy", 32'(busy), 32'd1);
        cyc();
        chk("empty_c2_done", 32'(done), 32'd1);
        count_rd(10, n_rd);
        chk("empty_no_rd", n_rd, 0);

        repeat (5) cyc();
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
